// File: rtl/cache_write_interface.sv
// Purpose : accepts write transactions (id, beats-1, word address) and a stream of
//           IWIDTH-bit beats, and writes them to the cache SRAM one CWIDTH word per cycle.
//           Word addresses wrap inside the cache line. One completion response (id) is
//           returned per transaction.
// Latency : the first cache write happens 1 cycle after a beat is accepted. The response
//           becomes valid 1 cycle after the final word is written.
// Backpressure: OUT_ready and OUT_dready deassert when the header queue or the beat buffer
//           is full. IN_CACHE_ready low holds the pending access and retries it.
//           An unaccepted response (IN_bready low) blocks the final write of the next
//           transaction.
//
// Ports:
//   clk, rst                     clock, async active-high reset
//   IN_valid/OUT_ready           header handshake: IN_id, IN_len (beats-1), IN_addr
//   IN_dvalid/OUT_dready         beat handshake: IN_data (word 0 in LSBs), IN_dlast
//   OUT_bvalid/IN_bready         completion response: OUT_bid
//   OUT_CACHE_ce/we (active low) SRAM access: OUT_CACHE_addr, OUT_CACHE_data,
//                                accepted when IN_CACHE_ready is high
module cache_write_interface #(
  parameter int ADDR_BITS = 10,
  parameter int LEN_BITS  = 8,
  parameter int IWIDTH    = 128,
  parameter int CWIDTH    = 32,
  parameter int CL_WBITS  = 4,
  parameter int ID_LEN    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  // transaction header
  output logic                 OUT_ready,
  input  logic                 IN_valid,
  input  logic [ID_LEN-1:0]    IN_id,
  input  logic [LEN_BITS-1:0]  IN_len,
  input  logic [ADDR_BITS-1:0] IN_addr,
  // data beats
  output logic                 OUT_dready,
  input  logic                 IN_dvalid,
  input  logic [IWIDTH-1:0]    IN_data,
  input  logic                 IN_dlast,
  // write response
  input  logic                 IN_bready,
  output logic                 OUT_bvalid,
  output logic [ID_LEN-1:0]    OUT_bid,
  // cache SRAM port
  input  logic                 IN_CACHE_ready,
  output logic                 OUT_CACHE_ce,
  output logic                 OUT_CACHE_we,
  output logic [ADDR_BITS-1:0] OUT_CACHE_addr,
  output logic [CWIDTH-1:0]    OUT_CACHE_data
);

  localparam int WNUM     = IWIDTH / CWIDTH;
  localparam int SUB_BITS = $clog2(WNUM);
  localparam logic [SUB_BITS-1:0] SUB_LAST = SUB_BITS'(WNUM - 1);

  // One header-queue entry. beat counts the beats of this transaction already written.
  typedef struct packed {
    logic                 vld;
    logic [ID_LEN-1:0]    id;
    logic [LEN_BITS-1:0]  len;
    logic [ADDR_BITS-1:0] addr;
    logic [LEN_BITS-1:0]  beat;
  } hdr_t;

  hdr_t cur;
  hdr_t nxt;
  hdr_t new_hdr;

  // Beat buffer, viewed as WNUM cache words (word 0 = least significant).
  logic [WNUM-1:0][CWIDTH-1:0] bbuf_words;
  logic                        bbuf_vld;
  logic                        bbuf_last;
  logic [SUB_BITS-1:0]         sub;

  logic              rsp_vld;
  logic [ID_LEN-1:0] rsp_id;

  logic sub_last;
  logic beat_last;
  logic stall;
  logic issue;
  logic wr_ok;
  logic beat_done;
  logic finishing;
  logic hdr_acc;
  logic hdr_to_cur;
  logic beat_acc;
  logic [CL_WBITS-1:0] wp;

  assign new_hdr = '{vld: 1'b1, id: IN_id, len: IN_len, addr: IN_addr, beat: '0};

  // ---------------------------------------------------------------------------
  // Issue / completion decode
  // ---------------------------------------------------------------------------
  assign sub_last  = (sub == SUB_LAST);
  assign beat_last = (cur.beat == cur.len);

  // The final word is held back while an older response still occupies the
  // response register. Finishing in that state would overwrite the older response.
  assign stall     = cur.vld && sub_last && beat_last && rsp_vld && !IN_bready;
  assign issue     = cur.vld && bbuf_vld && !stall;
  assign wr_ok     = issue && IN_CACHE_ready;
  assign beat_done = wr_ok && sub_last;
  assign finishing = beat_done && beat_last;

  // Both ready signals look ahead to slots freed this cycle, so streams run without bubbles.
  assign OUT_ready  = !nxt.vld || finishing;
  assign OUT_dready = !bbuf_vld || beat_done;

  assign hdr_acc    = IN_valid && OUT_ready;
  assign beat_acc   = IN_dvalid && OUT_dready;
  // cur is free, or it is being vacated and no queued header is waiting to take it.
  assign hdr_to_cur = !cur.vld || (finishing && !nxt.vld);

  // Word offset within the transaction. Only the low CL_WBITS bits matter, because the
  // sum wraps inside the line.
  assign wp = CL_WBITS'({cur.beat, sub});

  // ---------------------------------------------------------------------------
  // Cache port
  // ---------------------------------------------------------------------------
  always_comb begin
    OUT_CACHE_ce   = !issue;
    OUT_CACHE_we   = !issue;
    OUT_CACHE_addr = {cur.addr[ADDR_BITS-1:CL_WBITS], cur.addr[CL_WBITS-1:0] + wp};
    OUT_CACHE_data = bbuf_words[sub];
  end

  assign OUT_bvalid = rsp_vld;
  assign OUT_bid    = rsp_id;

  // ---------------------------------------------------------------------------
  // Header queue
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= '0;
    end else if (hdr_acc && hdr_to_cur) begin
      cur <= new_hdr;
    end else if (finishing) begin
      // Promote the queued header. If nxt is empty, this clears cur.vld.
      cur <= nxt;
    end else if (beat_done) begin
      cur.beat <= cur.beat + LEN_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nxt <= '0;
    end else if (hdr_acc && !hdr_to_cur) begin
      nxt <= new_hdr;
    end else if (finishing) begin
      nxt.vld <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Beat buffer and sub-word pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bbuf_vld   <= 1'b0;
      bbuf_last  <= 1'b0;
      bbuf_words <= '0;
    end else if (beat_acc) begin
      bbuf_vld   <= 1'b1;
      bbuf_last  <= IN_dlast;
      bbuf_words <= IN_data;
    end else if (beat_done) begin
      bbuf_vld <= 1'b0;
    end
  end

  // WNUM is a power of two, so the pointer returns to 0 after the last word on its own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub <= '0;
    end else if (wr_ok) begin
      sub <= sub + SUB_BITS'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Response register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_vld <= 1'b0;
      rsp_id  <= '0;
    end else if (finishing) begin
      rsp_vld <= 1'b1;
      rsp_id  <= cur.id;
    end else if (IN_bready) begin
      rsp_vld <= 1'b0;
    end
  end

  // The beat that completes a transaction must carry dlast.
  a_dlast_on_final: assert property (@(posedge clk) disable iff (rst) finishing |-> bbuf_last);

endmodule

// File: tb/tb_cache_write_interface.sv
module tb_cache_write_interface;

  logic         clk;
  logic         rst;
  logic         out_ready;
  logic         in_valid;
  logic [1:0]   in_id;
  logic [7:0]   in_len;
  logic [9:0]   in_addr;
  logic         out_dready;
  logic         in_dvalid;
  logic [127:0] in_data;
  logic         in_dlast;
  logic         in_bready;
  logic         out_bvalid;
  logic [1:0]   out_bid;
  logic         cache_ready;
  logic         cache_ce;
  logic         cache_we;
  logic [9:0]   cache_addr;
  logic [31:0]  cache_data;

  cache_write_interface dut (
    .clk            (clk),
    .rst            (rst),
    .OUT_ready      (out_ready),
    .IN_valid       (in_valid),
    .IN_id          (in_id),
    .IN_len         (in_len),
    .IN_addr        (in_addr),
    .OUT_dready     (out_dready),
    .IN_dvalid      (in_dvalid),
    .IN_data        (in_data),
    .IN_dlast       (in_dlast),
    .IN_bready      (in_bready),
    .OUT_bvalid     (out_bvalid),
    .OUT_bid        (out_bid),
    .IN_CACHE_ready (cache_ready),
    .OUT_CACHE_ce   (cache_ce),
    .OUT_CACHE_we   (cache_we),
    .OUT_CACHE_addr (cache_addr),
    .OUT_CACHE_data (cache_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0;
  int failures = 0;

  // Observed writes and responses, sampled mid-cycle.
  logic [9:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  logic [1:0]  rsp_id[$];
  int          rsp_cyc[$];
  // Expected writes
  logic [9:0]  exp_addr[$];
  logic [31:0] exp_data[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (!cache_ce && !cache_we && cache_ready) begin
        wr_addr.push_back(cache_addr);
        wr_data.push_back(cache_data);
        wr_cyc.push_back(cyc);
      end
      if (out_bvalid && in_bready) begin
        rsp_id.push_back(out_bid);
        rsp_cyc.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    rsp_id.delete(); rsp_cyc.delete();
    exp_addr.delete(); exp_data.delete();
  endtask

  // All stimulus tasks are entered and left 1ns after a rising edge.
  task automatic send_hdr(input logic [1:0] id, input logic [7:0] len, input logic [9:0] addr);
    int  n = 0;
    bit  done = 0;
    in_valid = 1'b1; in_id = id; in_len = len; in_addr = addr;
    while (!done) begin
      @(negedge clk);
      done = out_ready;
      @(posedge clk); #1;
      n++;
      if (!done && n > 200) begin
        check("hdr_accept_timeout", 0, 1);
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] data, input logic last);
    int  n = 0;
    bit  done = 0;
    in_dvalid = 1'b1; in_data = data; in_dlast = last;
    while (!done) begin
      @(negedge clk);
      done = out_dready;
      @(posedge clk); #1;
      n++;
      if (!done && n > 200) begin
        check("beat_accept_timeout", 0, 1);
        done = 1;
      end
    end
    in_dvalid = 1'b0;
    in_dlast  = 1'b0;
  endtask

  task automatic wait_writes(input int n, input string tag);
    int k = 0;
    while (wr_addr.size() < n && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (wr_addr.size() < n) check(tag, wr_addr.size(), n);
  endtask

  task automatic wait_rsp(input int n, input string tag);
    int k = 0;
    while (rsp_id.size() < n && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (rsp_id.size() < n) check(tag, rsp_id.size(), n);
  endtask

  task automatic compare_writes(input string t, input bit contiguous);
    check({t, "_count"}, wr_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (i < wr_addr.size()) begin
        check($sformatf("%s_addr%0d", t, i), wr_addr[i], exp_addr[i]);
        check($sformatf("%s_data%0d", t, i), wr_data[i], exp_data[i]);
        if (contiguous && i > 0)
          check($sformatf("%s_gap%0d", t, i), wr_cyc[i] - wr_cyc[i-1], 1);
      end
    end
  endtask

  function automatic logic [127:0] mk_beat(input logic [31:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  initial begin
    logic [31:0] w1[4];
    rst = 1'b1; in_valid = 1'b0; in_id = '0; in_len = '0; in_addr = '0;
    in_dvalid = 1'b0; in_data = '0; in_dlast = 1'b0;
    in_bready = 1'b1; cache_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", out_ready, 1);
    check("rst_dready", out_dready, 1);
    check("rst_bvalid", out_bvalid, 0);
    check("rst_ce", cache_ce, 1);
    check("rst_we", cache_we, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: single beat, word order and response timing
    clear_logs();
    w1 = '{32'hAAAA5555, 32'h00000000, 32'h22221111, 32'h44443333};
    for (int i = 0; i < 4; i++) begin
      exp_addr.push_back(10'h010 + 10'(i));
      exp_data.push_back(w1[i]);
    end
    fork
      send_hdr(2'd1, 8'd0, 10'h010);
      send_beat(128'h44443333_22221111_00000000_AAAA5555, 1'b1);
    join
    wait_rsp(1, "t1_rsp_timeout");
    compare_writes("t1", 1'b1);
    check("t1_bid", rsp_id[0], 1);
    check("t1_rsp_lat", rsp_cyc[0] - wr_cyc[3], 1);

    // 2: address wrap inside the line
    clear_logs();
    exp_addr = '{10'h00E, 10'h00F, 10'h000, 10'h001};
    for (int i = 0; i < 4; i++) exp_data.push_back(32'h10 + 32'(i));
    fork
      send_hdr(2'd0, 8'd0, 10'h00E);
      send_beat(mk_beat(32'h10), 1'b1);
    join
    wait_rsp(1, "t2_rsp_timeout");
    compare_writes("t2", 1'b1);
    check("t2_bid", rsp_id[0], 0);

    // 3: back-to-back two-beat transactions
    clear_logs();
    for (int j = 0; j < 16; j++) begin
      exp_addr.push_back(j < 8 ? 10'h020 + 10'(j) : 10'h040 + 10'(j - 8));
      exp_data.push_back(32'hB0000000 + 32'(j));
    end
    fork
      begin
        send_hdr(2'd2, 8'd1, 10'h020);
        send_hdr(2'd3, 8'd1, 10'h040);
      end
      begin
        for (int b = 0; b < 4; b++)
          send_beat(mk_beat(32'hB0000000 + 32'(4 * b)), (b % 2) == 1);
      end
      begin
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("t3_ready_full", out_ready, 0);
      end
    join
    wait_rsp(2, "t3_rsp_timeout");
    compare_writes("t3", 1'b1);
    check("t3_bid0", rsp_id[0], 2);
    check("t3_bid1", rsp_id[1], 3);

    // 4: cache not ready for 3 cycles mid-beat
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      exp_addr.push_back(10'h100 + 10'(i));
      exp_data.push_back(32'hC0 + 32'(i));
    end
    fork
      send_hdr(2'd1, 8'd0, 10'h100);
      send_beat(mk_beat(32'hC0), 1'b1);
    join
    wait_writes(1, "t4_first_write_timeout");
    cache_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("t4_hold_ce%0d", k), cache_ce, 0);
      check($sformatf("t4_hold_addr%0d", k), cache_addr, 10'h101);
      check($sformatf("t4_hold_data%0d", k), cache_data, 32'hC1);
      check($sformatf("t4_hold_dready%0d", k), out_dready, 0);
      @(posedge clk); #1;
    end
    cache_ready = 1'b1;
    wait_rsp(1, "t4_rsp_timeout");
    compare_writes("t4", 1'b0);
    check("t4_bid", rsp_id[0], 1);

    // 5: response not taken; the final write of the second transaction stalls
    clear_logs();
    in_bready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_addr.push_back(10'h200 + 10'(i));
      exp_data.push_back(32'hD0 + 32'(i));
    end
    for (int i = 0; i < 4; i++) begin
      exp_addr.push_back(10'h300 + 10'(i));
      exp_data.push_back(32'hE0 + 32'(i));
    end
    fork
      begin
        send_hdr(2'd1, 8'd0, 10'h200);
        send_hdr(2'd2, 8'd0, 10'h300);
      end
      begin
        send_beat(mk_beat(32'hD0), 1'b1);
        send_beat(mk_beat(32'hE0), 1'b1);
      end
    join
    wait_writes(7, "t5_writes_timeout");
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("t5_stall_ce", cache_ce, 1);
    check("t5_stall_bvalid", out_bvalid, 1);
    check("t5_stall_bid", out_bid, 1);
    check("t5_stall_count", wr_addr.size(), 7);
    @(posedge clk); #1;
    in_bready = 1'b1;
    wait_rsp(2, "t5_rsp_timeout");
    compare_writes("t5", 1'b0);
    check("t5_bid0", rsp_id[0], 1);
    check("t5_bid1", rsp_id[1], 2);

    // 6: reset in the middle of a transaction
    clear_logs();
    fork
      send_hdr(2'd2, 8'd0, 10'h050);
      send_beat(mk_beat(32'hF0), 1'b1);
    join
    wait_writes(2, "t6_writes_timeout");
    rst = 1'b1;
    #1;
    check("t6_rst_ce", cache_ce, 1);
    check("t6_rst_we", cache_we, 1);
    check("t6_rst_bvalid", out_bvalid, 0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    check("t6_ready", out_ready, 1);
    check("t6_dready", out_dready, 1);
    repeat (5) begin @(posedge clk); #1; end
    check("t6_no_rsp", rsp_id.size(), 0);
    check("t6_no_more_writes", wr_addr.size(), 2);
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      exp_addr.push_back(10'h060 + 10'(i));
      exp_data.push_back(32'h60 + 32'(i));
    end
    fork
      send_hdr(2'd3, 8'd0, 10'h060);
      send_beat(mk_beat(32'h60), 1'b1);
    join
    wait_rsp(1, "t6_rsp_timeout");
    compare_writes("t6", 1'b1);
    check("t6_bid", rsp_id[0], 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
